// File: rtl/reg_file_param.sv
// ---------------------------------------------------------------------------
// reg_file_param
//
// Parametrised register file for the CPU datapath. It has one synchronous
// write port and two combinational read ports. Options are a hardwired-zero
// entry 0 and write-to-read bypass. A CLEAR request starts a sweep that zeroes
// one entry per clock, so software can wipe the file without a reset.
//
// Parameters:
//   DATA_WIDTH   width of each entry and of IN / OUT1 / OUT2
//   ADDR_WIDTH   address width; the file holds 2**ADDR_WIDTH entries
//   ZERO_REG     1 = entry 0 always reads 0 and writes to it are discarded
//   BYPASS       1 = an accepted write is forwarded to a matching read port
//
// Ports:
//   CLK            system clock, rising edge
//   RESET          asynchronous active-low reset
//   IN             write data
//   INADDRESS      write address
//   WRITE          write request, sampled on rising CLK
//   OUT1ADDRESS    read port 1 address
//   OUT2ADDRESS    read port 2 address
//   OUT1           read port 1 data (combinational)
//   OUT2           read port 2 data (combinational)
//   CLEAR          start a clear sweep, sampled on rising CLK
//   BUSY           high while the sweep is running
//   WRITE_REJECT   one-cycle registered pulse: a write arrived during a sweep
// ---------------------------------------------------------------------------
module reg_file_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int ZERO_REG   = 0,
    parameter int BYPASS     = 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [DATA_WIDTH-1:0] IN,
    input  logic [ADDR_WIDTH-1:0] INADDRESS,
    input  logic                  WRITE,
    input  logic [ADDR_WIDTH-1:0] OUT1ADDRESS,
    input  logic [ADDR_WIDTH-1:0] OUT2ADDRESS,
    output logic [DATA_WIDTH-1:0] OUT1,
    output logic [DATA_WIDTH-1:0] OUT2,
    input  logic                  CLEAR,
    output logic                  BUSY,
    output logic                  WRITE_REJECT
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        IDLE,
        SWEEP
    } state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic [ADDR_WIDTH-1:0] r_sweepCnt;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic                  r_writeReject;

    logic w_idle;
    logic w_writeAccept;
    logic w_zeroEntryWrite;
    logic w_writeStore;
    logic w_bypassOk;

    assign w_idle           = (r_state == IDLE);
    assign w_writeAccept    = WRITE && w_idle;
    // An accepted write to the hardwired-zero entry is silently swallowed;
    // it is not a rejection, so it never raises WRITE_REJECT.
    assign w_zeroEntryWrite = (ZERO_REG != 0) && (INADDRESS == '0);
    assign w_writeStore     = w_writeAccept && !w_zeroEntryWrite;
    // Forwarding only happens for writes that will really land in storage,
    // which also rules out forwarding while a sweep owns the file.
    assign w_bypassOk       = (BYPASS != 0) && w_writeStore;

    assign BUSY         = (r_state == SWEEP);
    assign WRITE_REJECT = r_writeReject;

    // State register for the clear sweep.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: CLEAR only matters in IDLE, so a request during a
    // sweep neither restarts nor extends it. The sweep ends after the last
    // entry has been cleared.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (CLEAR) begin
                    w_nextState = SWEEP;
                end
            end
            SWEEP: begin
                if (r_sweepCnt == LAST_ADDR) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Sweep counter: armed to 0 when the sweep starts, then steps once per
    // sweep cycle. Stepping past the last entry wraps it back to 0.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_sweepCnt <= '0;
        end else if (w_idle) begin
            if (CLEAR) begin
                r_sweepCnt <= '0;
            end
        end else begin
            r_sweepCnt <= r_sweepCnt + 1'b1;
        end
    end

    // Storage: normal writes only in IDLE; during a sweep the entry selected
    // by the counter is zeroed each cycle. A write that shares its cycle with
    // the CLEAR request is still performed, because the state is still IDLE.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_writeStore) begin
            r_mem[INADDRESS] <= IN;
        end else if (!w_idle) begin
            r_mem[r_sweepCnt] <= '0;
        end
    end

    // Reject pulse: every write request seen during a sweep produces a pulse
    // in the following cycle, so consecutive dropped writes give consecutive
    // pulses.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_writeReject <= 1'b0;
        end else begin
            r_writeReject <= WRITE && !w_idle;
        end
    end

    // Read port 1: stored value, overridden by the bypassed write data, and
    // finally forced to 0 for the hardwired-zero entry.
    always_comb begin
        OUT1 = r_mem[OUT1ADDRESS];
        if (w_bypassOk && (INADDRESS == OUT1ADDRESS)) begin
            OUT1 = IN;
        end
        if ((ZERO_REG != 0) && (OUT1ADDRESS == '0)) begin
            OUT1 = '0;
        end
    end

    // Read port 2: same priority as read port 1.
    always_comb begin
        OUT2 = r_mem[OUT2ADDRESS];
        if (w_bypassOk && (INADDRESS == OUT2ADDRESS)) begin
            OUT2 = IN;
        end
        if ((ZERO_REG != 0) && (OUT2ADDRESS == '0)) begin
            OUT2 = '0;
        end
    end

endmodule
